// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO helpers: Gray/binary conversion and depth
//               derivation. Used by both the read-side and write-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Widest pointer the helpers handle. Callers cast their narrower pointer
  // up to this width and cast the result back down to their own width.
  localparam int MAX_PTR_W = 32;

  // Number of memory words addressed by an address of the given width.
  function automatic int depth_of(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary. Each binary bit is the XOR of the Gray bits at and above
  // it, which is the XOR of every right shift of the Gray word. Bits above
  // the caller's width are zero, so they do not disturb the result.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = g;
    for (int s = 1; s < MAX_PTR_W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rptr_empty_fwft_if.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_fwft_if
// Description : Signal bundle of the read-side FIFO block: synchronised write
//               pointer in, memory read port, Gray read pointer out, and the
//               first-word-fall-through consumer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface rptr_empty_fwft_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);

  // Pointer side
  logic [ADDR_WIDTH:0]   wptr_sync;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  rempty;

  // Memory read port
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Consumer handshake
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  // Status
  logic [ADDR_WIDTH:0]   rlevel;
  logic                  level_err;

  // The read-side block itself
  modport slave (
    input  wptr_sync,
    input  mem_rdata,
    input  dout_ready,
    output raddr,
    output rptr,
    output rempty,
    output dout,
    output dout_valid,
    output rlevel,
    output level_err
  );

  // Whatever surrounds the block: memory, synchroniser and consumer
  modport master (
    output wptr_sync,
    output mem_rdata,
    output dout_ready,
    input  raddr,
    input  rptr,
    input  rempty,
    input  dout,
    input  dout_valid,
    input  rlevel,
    input  level_err
  );

endinterface : rptr_empty_fwft_if
`default_nettype wire

// File: rtl/rptr_empty_fwft.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_fwft
// Description : Read-domain pointer, empty detection and first-word-fall-
//               through output register of the async FIFO. Also reports a
//               registered occupancy and a sticky pointer-consistency error.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic        rclk,
  input  wire logic        rst,
  rptr_empty_fwft_if.slave bus
);

  localparam int                PTR_W   = ADDR_WIDTH + 1;
  localparam int                DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]      r_rbin;        // binary read pointer, modulo 2*DEPTH
  logic [PTR_W-1:0]      r_rptr;        // Gray copy of r_rbin, crosses domains
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic [PTR_W-1:0]      r_rlevel;
  logic                  r_level_err;

  // --------------------------------------------------------------------------
  // Combinational terms
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]      w_rbin_next;
  logic [PTR_W-1:0]      w_rptr_next;
  logic [PTR_W-1:0]      w_wbin;
  logic [PTR_W-1:0]      w_diff;
  logic                  w_level_over;
  logic                  w_rempty;
  logic                  w_stage_free;
  logic                  w_fetch;
  logic                  w_consume;

  assign w_rbin_next  = r_rbin + PTR_ONE;
  assign w_rptr_next  = PTR_W'(bin2gray(MAX_PTR_W'(w_rbin_next)));

  // Occupancy is taken in binary; the subtraction wraps modulo 2*DEPTH so a
  // write pointer that has lapped the read pointer's MSB still gives 0..DEPTH.
  assign w_wbin       = PTR_W'(gray2bin(MAX_PTR_W'(bus.wptr_sync)));
  assign w_diff       = w_wbin - r_rbin;
  assign w_level_over = (w_diff > DEPTH_P);

  // Exact Gray equality: the extra MSB separates empty from full. Both sides
  // are registers, so a stale wptr_sync can only make this pessimistically 1.
  assign w_rempty     = (r_rptr == bus.wptr_sync);

  // dout_ready only steers next-state; nothing it feeds reaches raddr/rptr
  // within the same cycle.
  assign w_stage_free = ~r_dout_valid | bus.dout_ready;
  assign w_fetch      = ~w_rempty & w_stage_free;
  assign w_consume    = r_dout_valid & bus.dout_ready;

  // --------------------------------------------------------------------------
  // Read pointer: advance in binary and Gray together on every fetch
  // --------------------------------------------------------------------------
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_rbin <= '0;
      r_rptr <= '0;
    end else if (w_fetch) begin
      r_rbin <= w_rbin_next;
      r_rptr <= w_rptr_next;
    end
  end

  // --------------------------------------------------------------------------
  // FWFT output stage: load on fetch, drop valid on a consume with no refill
  // --------------------------------------------------------------------------
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_fetch) begin
      r_dout       <= bus.mem_rdata;
      r_dout_valid <= 1'b1;
    end else if (w_consume) begin
      r_dout_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy register and sticky over-depth error
  // --------------------------------------------------------------------------
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_rlevel    <= '0;
      r_level_err <= 1'b0;
    end else begin
      r_rlevel <= w_diff;
      if (w_level_over) begin
        r_level_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.raddr      = r_rbin[ADDR_WIDTH-1:0];
  assign bus.rptr       = r_rptr;
  assign bus.rempty     = w_rempty;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.rlevel     = r_rlevel;
  assign bus.level_err  = r_level_err;

endmodule : rptr_empty_fwft
`default_nettype wire

// File: doc/rptr_empty_fwft.md
Name: rptr_empty_fwft

Overview:
Read-side pointer, empty and output stage of the async FIFO, in the read clock domain. Compares its own Gray read pointer against the synchronised write pointer and drives the memory read address. A first-word-fall-through output register, with a valid/ready handshake, presents data to the consumer. Also reports registered occupancy and a sticky pointer-consistency error. The write-side full logic consumes the rptr this block produces, after synchronisation.

Parameters:
ADDR_WIDTH, 3, memory address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
DATA_WIDTH, 8, word width

Ports:
rclk  in  1  read clock; single clock domain
rst  in  1  reset, asynchronous, active-high
wptr_sync  in  ADDR_WIDTH+1  Gray write pointer, already 2-flop synchronised into rclk
mem_rdata  in  DATA_WIDTH  memory read data, combinational from raddr
raddr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0]
rptr  out  ADDR_WIDTH+1  registered Gray read pointer, to the write-domain synchroniser
rempty  out  1  raw FIFO empty: rptr == wptr_sync (combinational compare of registered values)
dout  out  DATA_WIDTH  output data register
dout_valid  out  1  dout holds an unconsumed word
dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready
rlevel  out  ADDR_WIDTH+1  registered words in memory, excluding dout: 0..DEPTH
level_err  out  1  sticky: computed occupancy exceeded DEPTH

Behaviour:
- Reset (async, immediate): rbin=0, rptr=0, dout=0, dout_valid=0, rlevel=0, level_err=0. rempty follows the compare, so it reads 1 when wptr_sync=0.
- Fetch condition: fetch = ~rempty & (~dout_valid | dout_ready).
- On fetch at a rclk edge:
  - dout <= mem_rdata (addressed by current raddr), dout_valid <= 1.
  - rbin <= rbin+1; rptr <= gray(rbin+1), where gray(x) = x ^ (x>>1).
- No fetch, and dout_valid & dout_ready: dout_valid <= 0; dout holds its last value.
- Neither case: all state holds. dout is stable while dout_valid & ~dout_ready.
- Latency:
  - Word enters empty FIFO and stage empty: dout_valid rises on the first rclk edge after wptr_sync changes.
  - Full throughput is one word per cycle with dout_ready held high.
- Simultaneous consume and fetch: dout is replaced by the next word and dout_valid stays 1, with no bubble.
- Wrap-around: rbin counts modulo 2*DEPTH, e.g. Gray 1000 -> 0000 for ADDR_WIDTH=3. raddr wraps DEPTH-1 -> 0. Empty is exact Gray equality, so the MSB distinguishes empty from full.
- Pessimism: wptr_sync lags the true write pointer. rempty may be stale-high but never falsely low, so underflow is impossible by construction.
- Occupancy:
  - wbin_s = gray2bin(wptr_sync); rlevel <= wbin_s - rbin, modulo 2**(ADDR_WIDTH+1).
  - The value is registered: one cycle after either operand changes.
- level_err: set when the computed difference exceeds DEPTH, which indicates a corrupt or multi-bit-skewed pointer. Cleared only by rst. Fetch behaviour is unaffected.
- No combinational path from dout_ready to raddr/rptr; dout_ready affects only next-state.

Decomposition:
- Shared package fifo_pkg holds:
  - gray2bin and bin2gray functions, parameterised by width
  - DEPTH derivation as a localparam expression
  - also used by the write-side block
- No sub-module: the FWFT output register stays inline. The synchroniser (sync_w2r) is a separate existing stage outside this block.

Test Plan:
All scenarios use ADDR_WIDTH=3, DATA_WIDTH=8.
- Reset, wptr_sync=0000 -> rempty=1, dout_valid=0, rptr=0000, raddr=0, rlevel=0, level_err=0.
- Step wptr_sync to 0001, mem_rdata=A5, dout_ready=0 -> next edge dout=A5, dout_valid=1, rptr=0001, raddr=1, rempty=1. dout holds A5 for 5 cycles of ready=0.
- wptr_sync=0010 (3 written), stage full, ready=0 -> no fetch, rlevel=2.
  - Then ready=1 with mem words 11,22 -> dout A5,11,22 on consecutive cycles, rptr 0001->0011->0010.
  - dout_valid falls the cycle after 22 is accepted.
- Stream 17 words with ready=1 -> rptr passes 0100 ... 1000 -> 0000, raddr 7->0. rempty never asserts while words remain, and data order is preserved.
- rbin=0, wptr_sync=1100 (bin 8) -> rlevel=8 one cycle later, level_err=0.
  - Then wptr_sync=1101 (bin 9) -> level_err=1, held until rst.
- Assert rst mid-stream with dout_valid=1 -> dout_valid=0, dout=0, rptr=0000 without waiting for rclk. Normal fetch resumes after deassertion.
